// File: rtl/regfile_fwd_sb_pkg.sv
// regfile_fwd_sb_pkg
// Shared definitions for the forwarding register file: default bus types,
// scrub FSM state encodings and the active levels of the control strobes.
// No ports; imported by regfile_rd_port and regfile_fwd_sb.
package regfile_fwd_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Default-width register data and register address buses.
  typedef logic [DATA_W_DEF-1:0] RegBus;
  typedef logic [ADDR_W_DEF-1:0] RegAddrBus;

  // Scrub state machine: SCRUB zeroes the array, RUN serves the pipeline.
  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } scrub_state_e;

  // Active levels of reset and of the write/read strobes.
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port
// One combinational read port: priority mux over reset, read enable,
// register zero, the forwarding stages (youngest first), the same-cycle
// write-back bypass and finally the array word.
// Ports:
//   rst                  synchronous active-high reset (forces data to 0)
//   rd_en, rd_addr       this port's enable and register address
//   fwd_we/addr/data/vld packed per-stage forwarding sources, index 0 youngest
//   wb_we/addr/data      write-back port, used for the same-cycle bypass
//   arr_data             array[rd_addr], looked up by the parent
//   rd_data              selected read data
//   hz                   load-use hazard: matching stage result not yet final
module regfile_rd_port
  import regfile_fwd_sb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_FWD-1:0]         fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0]  fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]         fwd_vld,
  input  logic                       wb_we,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [DATA_W-1:0]          arr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       hz
);

  logic hit;

  always_comb begin
    rd_data = '0;
    hz      = 1'b0;
    hit     = 1'b0;
    if (rst != RstEnable && rd_en == ReadEnable && rd_addr != '0) begin
      // The first matching stage owns the lookup. If its result is not final
      // the port returns 0 and flags a hazard; older stages and write-back
      // must not be consulted, since they hold stale values.
      for (int s = 0; s < NUM_FWD; s++) begin
        if (!hit && fwd_we[s] == WriteEnable &&
            fwd_addr[s*ADDR_W +: ADDR_W] == rd_addr) begin
          hit = 1'b1;
          if (fwd_vld[s]) begin
            rd_data = fwd_data[s*DATA_W +: DATA_W];
          end else begin
            hz = 1'b1;
          end
        end
      end
      if (!hit) begin
        if (wb_we == WriteEnable && wb_addr == rd_addr) begin
          rd_data = wb_data;
        end else begin
          rd_data = arr_data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// regfile_fwd_sb
// ID-stage register file with NUM_RD combinational read ports, one
// write-back port, NUM_FWD-stage forwarding with load-use hazard detection,
// a post-reset scrub that zeroes the array, and a saturating counter of
// hazard-stall cycles.
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   rd_en/addr/data       packed read ports, port p at [p*W +: W]
//   wb_we/addr/data       write-back write port
//   fwd_we/addr/data/vld  packed forwarding sources, index 0 youngest (EX)
//   stall                 hold IF/ID: scrub running or any port hazard
//   init_busy             scrub in progress; high exactly while the FSM is in
//                         SCRUB (or rst is held), so it doubles as the FSM
//                         state observation point
//   stall_cnt             saturating count of hazard-stall cycles in RUN
//
// Handshake: there is no valid/ready pair here. stall is a combinational
// back-pressure level; while it is high the upstream stages must hold their
// state, and write-back is assumed idle during the scrub (writes issued
// then are dropped).
module regfile_fwd_sb
  import regfile_fwd_sb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wb_we,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [NUM_FWD-1:0]         fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0]  fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  input  logic [NUM_FWD-1:0]         fwd_vld,
  output logic                       stall,
  output logic                       init_busy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  scrub_state_e      state;
  logic [ADDR_W-1:0] idx;
  logic [NUM_RD-1:0] hz;
  logic [DATA_W-1:0] arr_rd [NUM_RD];

  // Read ports.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign arr_rd[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD)
    ) u_rd_port (
      .rst      (rst),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .fwd_we   (fwd_we),
      .fwd_addr (fwd_addr),
      .fwd_data (fwd_data),
      .fwd_vld  (fwd_vld),
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .arr_data (arr_rd[p]),
      .rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .hz       (hz[p])
    );
  end

  // rst is folded in so init_busy is already high in the reset cycle,
  // before the FSM register has been forced to SCRUB.
  assign init_busy = (rst == RstEnable) || (state == ST_SCRUB);
  assign stall     = init_busy || (|hz);

  // Scrub FSM: one entry zeroed per cycle, DEPTH cycles after rst falls.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state <= ST_SCRUB;
      idx   <= '0;
    end else begin
      case (state)
        ST_SCRUB: begin
          idx <= idx + ADDR_W'(1);
          if (idx == ADDR_W'(DEPTH - 1)) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Array: the scrub owns the write port while active; afterwards only
  // write-back writes, and register zero is never written.
  always_ff @(posedge clk) begin
    if (rst != RstEnable) begin
      if (state == ST_SCRUB) begin
        mem[idx] <= '0;
      end else if (wb_we == WriteEnable && wb_addr != '0) begin
        mem[wb_addr] <= wb_data;
      end
    end
  end

  // Hazard-stall counter: counts only hazard stalls, not scrub stalls.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cnt <= '0;
    end else if (state == ST_RUN && (|hz) && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// tb_regfile_fwd_sb
// Directed bench for regfile_fwd_sb with default parameters (DEPTH = 32).
// A table of single-cycle vectors covers the read priority mux; hand-written
// sequences cover reset, scrub length, mid-scrub reset, load-use resolution
// and counter saturation.
module tb_regfile_fwd_sb;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_RD  = 2;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 16;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_RD-1:0]         rd_en;
  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic                      wb_we;
  logic [ADDR_W-1:0]         wb_addr;
  logic [DATA_W-1:0]         wb_data;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_vld;
  logic                      stall;
  logic                      init_busy;
  logic [CNT_W-1:0]          stall_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  regfile_fwd_sb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_FWD (NUM_FWD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .fwd_we    (fwd_we),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .fwd_vld   (fwd_vld),
    .stall     (stall),
    .init_busy (init_busy),
    .stall_cnt (stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  rd_en;
    logic [4:0]  a0, a1;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [1:0]  fwd_we;
    logic [4:0]  f0a;
    logic [31:0] f0d;
    logic [4:0]  f1a;
    logic [31:0] f1d;
    logic [1:0]  fwd_vld;
    logic [31:0] e0, e1;
    logic        es;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [1:0] fwe, input logic [4:0] f0a, input logic [31:0] f0d,
    input logic [4:0] f1a, input logic [31:0] f1d, input logic [1:0] fv,
    input logic [31:0] e0, input logic [31:0] e1, input logic es);
    vec_t v;
    v.rd_en = re; v.a0 = a0; v.a1 = a1;
    v.wb_we = we; v.wb_addr = wa; v.wb_data = wd;
    v.fwd_we = fwe; v.f0a = f0a; v.f0d = f0d; v.f1a = f1a; v.f1d = f1d;
    v.fwd_vld = fv; v.e0 = e0; v.e1 = e1; v.es = es;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    rd_en = '0; rd_addr = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    fwd_we = '0; fwd_addr = '0; fwd_data = '0; fwd_vld = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    rd_en    = v.rd_en;
    rd_addr  = {v.a1, v.a0};
    wb_we    = v.wb_we;
    wb_addr  = v.wb_addr;
    wb_data  = v.wb_data;
    fwd_we   = v.fwd_we;
    fwd_addr = {v.f1a, v.f0a};
    fwd_data = {v.f1d, v.f0d};
    fwd_vld  = v.fwd_vld;
  endtask

  // Drop rst (called at a negedge) and count posedges until init_busy falls.
  task automatic release_count(output int n);
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;
  int exp_cnt;

  initial begin
    idle();
    // ---- reset state ----
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    repeat (3) @(negedge clk);
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_rd1", rd_data[63:32], 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'd1);
    chk("reset_busy", {31'b0, init_busy}, 32'd1);
    chk("reset_cnt", {16'b0, stall_cnt}, 32'd0);

    // ---- first scrub: 32 cycles ----
    release_count(n);
    chk("scrub_len", n, 32);
    @(negedge clk);
    chk("run_stall", {31'b0, stall}, 32'd0);

    // ---- preload r7, then reset: scrub must clear it ----
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    #1;
    chk("r7_preload", rd_data[31:0], 32'hDEADBEEF);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_r7", rd_data[31:0], 32'h0);
    @(negedge clk);
    release_count(n);
    chk("scrub_len2", n, 32);
    @(negedge clk);
    chk("r7_scrubbed", rd_data[31:0], 32'h0);

    // ---- reset at idx 10 during scrub ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {31'b0, init_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    release_count(n);
    chk("scrub_restart_len", n, 32);
    @(negedge clk);
    idle();

    // ---- table-driven priority vectors ----
    //            re    a0  a1  we wa  wd            fwe   f0a f0d        f1a f1d   fv     e0            e1            es
    tbl.push_back(mk(2'b01, 5,  0, 1, 5, 32'h11111111, 2'b00, 0, 0,          0, 0,    2'b00, 32'h11111111, 32'h0,        0));
    tbl.push_back(mk(2'b11, 5,  5, 0, 0, 0,            2'b00, 0, 0,          0, 0,    2'b00, 32'h11111111, 32'h11111111, 0));
    tbl.push_back(mk(2'b01, 3,  0, 1, 3, 32'hC,        2'b11, 3, 32'hA,      3, 32'hB, 2'b11, 32'hA,       32'h0,        0));
    tbl.push_back(mk(2'b11, 3,  3, 1, 3, 32'hC,        2'b10, 3, 32'hA,      3, 32'hB, 2'b11, 32'hB,       32'hB,        0));
    tbl.push_back(mk(2'b11, 3,  3, 1, 3, 32'hC,        2'b00, 3, 32'hA,      3, 32'hB, 2'b11, 32'hC,       32'hC,        0));
    tbl.push_back(mk(2'b11, 3,  0, 0, 0, 0,            2'b00, 0, 0,          0, 0,    2'b00, 32'hC,        32'h0,        0));
    tbl.push_back(mk(2'b11, 0,  0, 1, 0, 32'hFFFFFFFF, 2'b11, 0, 32'h1234,   0, 32'h5678, 2'b00, 32'h0,    32'h0,        0));
    tbl.push_back(mk(2'b11, 0,  0, 0, 0, 0,            2'b00, 0, 0,          0, 0,    2'b00, 32'h0,        32'h0,        0));
    tbl.push_back(mk(2'b00, 9,  9, 0, 0, 0,            2'b01, 9, 0,          0, 0,    2'b00, 32'h0,        32'h0,        0));
    tbl.push_back(mk(2'b11, 9,  9, 0, 0, 0,            2'b11, 9, 0,          9, 32'h55, 2'b10, 32'h0,      32'h0,        1));
    tbl.push_back(mk(2'b10, 0,  9, 0, 0, 0,            2'b10, 0, 0,          9, 32'h55, 2'b10, 32'h0,      32'h55,       0));
    tbl.push_back(mk(2'b11, 5,  9, 0, 0, 0,            2'b10, 0, 0,          9, 0,    2'b00, 32'h11111111, 32'h0,        1));
    tbl.push_back(mk(2'b01, 9,  0, 1, 9, 32'h77,       2'b01, 9, 32'h66,     0, 0,    2'b01, 32'h66,       32'h0,        0));
    tbl.push_back(mk(2'b11, 9,  4, 0, 0, 0,            2'b01, 4, 32'h99,     0, 0,    2'b01, 32'h77,       32'h99,       0));

    exp_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply_vec(tbl[i]);
      #1;
      chk($sformatf("vec%0d_rd0", i), rd_data[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data[63:32], tbl[i].e1);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].es});
      if (tbl[i].es) exp_cnt++;
      @(negedge clk);
    end
    idle();
    #1;
    chk("table_stall_cnt", {16'b0, stall_cnt}, exp_cnt);

    // ---- load-use resolved by the next stage ----
    fwd_we = 2'b01; fwd_addr = {5'd0, 5'd9}; fwd_vld = 2'b00;
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    #1;
    chk("lu_stall", {31'b0, stall}, 32'd1);
    chk("lu_rd1", rd_data[63:32], 32'h0);
    @(negedge clk);
    exp_cnt++;
    chk("lu_cnt_inc", {16'b0, stall_cnt}, exp_cnt);
    fwd_we = 2'b10; fwd_addr = {5'd9, 5'd0}; fwd_data = {32'h55, 32'h0}; fwd_vld = 2'b10;
    #1;
    chk("lu_resolved_stall", {31'b0, stall}, 32'd0);
    chk("lu_resolved_rd1", rd_data[63:32], 32'h55);
    @(negedge clk);
    chk("lu_cnt_hold", {16'b0, stall_cnt}, exp_cnt);

    // ---- counter saturation ----
    fwd_we = 2'b01; fwd_addr = {5'd0, 5'd9}; fwd_vld = 2'b00;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    repeat ((1 << CNT_W) + 5) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", {16'b0, stall_cnt}, 32'h0000FFFF);
    chk("sat_stall", {31'b0, stall}, 32'd1);

    // ---- reset clears the counter ----
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cnt_clear", {16'b0, stall_cnt}, 32'd0);
    chk("rst_rd0_zero", rd_data[31:0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
